// File: rtl/kmeans_pkg.sv
// Shared sizing, label/address types and FSM state encoding for the
// k-means iteration controller.
package kmeans_pkg;

  localparam int SAMPS   = 128;
  localparam int K       = 3;
  localparam int LABEL_W = (K > 1) ? $clog2(K) : 1;
  localparam int ADDR_W  = $clog2(SAMPS);

  typedef logic [LABEL_W-1:0] label_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    OUT,
    DONE
  } state_t;

endpackage

// File: rtl/kmeans_label_mem.sv
// Per-sample cluster label store: one synchronous write port and two
// asynchronous read ports (change compare and result streaming).
module kmeans_label_mem
  import kmeans_pkg::*;
#(
  parameter  int SAMPS = kmeans_pkg::SAMPS,
  parameter  int LW    = kmeans_pkg::LABEL_W,
  localparam int AW    = $clog2(SAMPS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [LW-1:0] wdata,
  input  logic [AW-1:0] cmp_addr,
  output logic [LW-1:0] cmp_data,
  input  logic [AW-1:0] out_addr,
  output logic [LW-1:0] out_data
);

  logic [LW-1:0] mem [SAMPS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign cmp_data = mem[cmp_addr];
  assign out_data = mem[out_addr];

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// Sequences one k-means job: host sample load, repeated engine passes until
// no label changes or the iteration limit, then streams the final labels.
module kmeans_iter_ctrl
  import kmeans_pkg::*;
#(
  parameter  int SAMPS     = kmeans_pkg::SAMPS,
  parameter  int K         = kmeans_pkg::K,
  parameter  int MAX_ITERS = 16,
  localparam int LW        = (K > 1) ? $clog2(K) : 1,
  localparam int AW        = $clog2(SAMPS),
  localparam int IW        = $clog2(MAX_ITERS) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          host_wr_valid_i,
  output logic          host_wr_ready_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic          eng_start_o,
  input  logic [AW-1:0] eng_addr_i,
  input  logic [LW-1:0] eng_class_i,
  input  logic          eng_label_valid_i,
  input  logic          eng_pass_done_i,
  output logic          class_valid_o,
  input  logic          class_ready_i,
  output logic [LW-1:0] class_o,
  output logic [AW-1:0] class_addr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          converged_o,
  output logic [IW-1:0] iters_o
);

  localparam int            CW        = $clog2(SAMPS) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPS - 1);
  localparam logic [IW-1:0] ITER_LIM  = IW'(MAX_ITERS);
  localparam logic [CW-1:0] CNT_SAT   = CW'(SAMPS);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] out_ptr;
  logic [IW-1:0] iter;
  logic [CW-1:0] change_cnt;
  logic          eng_pulse;
  logic          label_we;
  logic [LW-1:0] stored_label;
  logic [LW-1:0] out_label;
  logic          is_change;

  assign label_we  = (state == RUN) && eng_label_valid_i && !abort_i;
  assign is_change = (iter == '0) || (stored_label != eng_class_i);

  kmeans_label_mem #(
    .SAMPS (SAMPS),
    .LW    (LW)
  ) u_label_mem (
    .clk      (clk_i),
    .we       (label_we),
    .waddr    (eng_addr_i),
    .wdata    (eng_class_i),
    .cmp_addr (eng_addr_i),
    .cmp_data (stored_label),
    .out_addr (out_ptr),
    .out_data (out_label)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      out_ptr     <= '0;
      iter        <= '0;
      change_cnt  <= '0;
      eng_pulse   <= 1'b0;
      converged_o <= 1'b0;
      iters_o     <= '0;
    end else if (abort_i) begin
      state     <= IDLE;
      eng_pulse <= 1'b0;
    end else begin
      eng_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= LOAD;
            wr_ptr      <= '0;
            iter        <= '0;
            converged_o <= 1'b0;
            iters_o     <= '0;
          end
        end
        LOAD: begin
          if (host_wr_valid_i) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              state      <= RUN;
              eng_pulse  <= 1'b1;
              change_cnt <= '0;
            end
          end
        end
        RUN: begin
          // A label arriving with pass_done is still counted before CHECK reads change_cnt.
          if (eng_label_valid_i && is_change && (change_cnt != CNT_SAT))
            change_cnt <= change_cnt + 1'b1;
          if (eng_pass_done_i) state <= CHECK;
        end
        CHECK: begin
          iter    <= iter + 1'b1;
          iters_o <= iter + 1'b1;
          if (change_cnt == '0) begin
            state       <= OUT;
            converged_o <= 1'b1;
            out_ptr     <= '0;
          end else if ((iter + 1'b1) == ITER_LIM) begin
            state       <= OUT;
            converged_o <= 1'b0;
            out_ptr     <= '0;
          end else begin
            state      <= RUN;
            eng_pulse  <= 1'b1;
            change_cnt <= '0;
          end
        end
        OUT: begin
          if (class_ready_i) begin
            out_ptr <= out_ptr + 1'b1;
            if (out_ptr == LAST_ADDR) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr_o = '0;
    if (state == LOAD)     mem_addr_o = wr_ptr;
    else if (state == RUN) mem_addr_o = eng_addr_i;
  end

  assign busy_o          = (state != IDLE);
  assign host_wr_ready_o = (state == LOAD);
  assign mem_we_o        = (state == LOAD) && host_wr_valid_i;
  assign eng_start_o     = eng_pulse && !abort_i;
  assign class_valid_o   = (state == OUT) && !abort_i;
  assign class_addr_o    = (state == OUT) ? out_ptr : '0;
  assign class_o         = (state == OUT) ? out_label : '0;
  assign done_o          = (state == DONE) && !abort_i;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed job sequence with randomized labels/handshakes, checked against a
// pass-level model of label changes, convergence and result streaming.
module tb_kmeans_iter_ctrl;
  import kmeans_pkg::*;

  localparam int MAX_ITERS = 16;
  localparam int IW        = $clog2(MAX_ITERS) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          host_wr_valid = 1'b0;
  logic          host_wr_ready;
  addr_t         mem_addr;
  logic          mem_we;
  logic          eng_start;
  addr_t         eng_addr = '0;
  label_t        eng_class = '0;
  logic          eng_label_valid = 1'b0;
  logic          eng_pass_done = 1'b0;
  logic          class_valid;
  logic          class_ready = 1'b0;
  label_t        cls;
  addr_t         class_addr;
  logic          busy;
  logic          done;
  logic          converged;
  logic [IW-1:0] iters;

  int n_cmp = 0;
  int n_err = 0;

  // Model: labels currently held by the DUT store, and labels for the pass being driven.
  int unsigned store [SAMPS];
  int unsigned cur   [SAMPS];

  always #5 clk = ~clk;

  kmeans_iter_ctrl #(
    .SAMPS     (SAMPS),
    .K         (K),
    .MAX_ITERS (MAX_ITERS)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .abort_i           (abort),
    .host_wr_valid_i   (host_wr_valid),
    .host_wr_ready_o   (host_wr_ready),
    .mem_addr_o        (mem_addr),
    .mem_we_o          (mem_we),
    .eng_start_o       (eng_start),
    .eng_addr_i        (eng_addr),
    .eng_class_i       (eng_class),
    .eng_label_valid_i (eng_label_valid),
    .eng_pass_done_i   (eng_pass_done),
    .class_valid_o     (class_valid),
    .class_ready_i     (class_ready),
    .class_o           (cls),
    .class_addr_o      (class_addr),
    .busy_o            (busy),
    .done_o            (done),
    .converged_o       (converged),
    .iters_o           (iters)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_flags"}, {25'd0, busy, host_wr_ready, mem_we, eng_start, class_valid, done, converged}, 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_class"}, {cls, class_addr}, 0);
    chk({tag, "_iters"}, 32'(iters), 0);
  endtask

  // Starts a job from IDLE and writes SAMPS samples; ends on the first RUN cycle.
  task automatic load(input bit toggle);
    int nwr = 0;
    int cyc = 0;
    logic v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ready", host_wr_ready, 1);
    chk("load_iters_clr", 32'(iters), 0);
    chk("load_conv_clr", converged, 0);
    while (nwr < SAMPS && cyc < SAMPS * 3) begin
      v = toggle ? ((cyc % 2) == 0) : 1'b1;
      host_wr_valid = v;
      #1;
      chk("load_we", mem_we, v);
      if (v) begin
        chk("load_addr", 32'(mem_addr), nwr);
        nwr++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("load_count", nwr, SAMPS);
    host_wr_valid = 1'b1;
    #1;
    chk("run_we_blocked", mem_we, 0);
    chk("run_ready_low", host_wr_ready, 0);
    host_wr_valid = 1'b0;
  endtask

  task automatic wait_eng_start();
    bit seen = 0;
    for (int w = 0; w < 8 && !seen; w++) begin
      if (eng_start === 1'b1) seen = 1;
      else @(negedge clk);
    end
    chk("eng_start_seen", seen, 1);
  endtask

  task automatic gen(input int mode, input int p);
    int unsigned idx;
    for (int i = 0; i < SAMPS; i++) begin
      case (mode)
        0, 1:    cur[i] = (p == 1) ? $urandom_range(0, K - 1) : store[i];
        3:       cur[i] = (p == 2) ? $urandom_range(0, K - 1) : store[i];
        default: cur[i] = store[i];
      endcase
    end
    if (mode == 1 && p > 1) begin
      idx = p % SAMPS;
      cur[idx] = (store[idx] + 1) % K;
    end
    if (mode == 3 && p == 2) cur[0] = (store[0] + 1) % K;
  endtask

  // One engine pass over every sample with random idle gaps; pass_done rides on the last label.
  task automatic run_pass(input bit first, output int ch);
    int extra = 0;
    ch = 0;
    for (int i = 0; i < SAMPS; i++)
      if (first || cur[i] != store[i]) ch++;
    if (ch > SAMPS) ch = SAMPS;
    wait_eng_start();
    for (int i = 0; i < SAMPS; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        eng_label_valid = 1'b0;
        eng_addr = addr_t'($urandom);
        @(negedge clk);
        if (eng_start === 1'b1) extra++;
      end
      eng_addr = addr_t'(i);
      eng_class = label_t'(cur[i]);
      eng_label_valid = 1'b1;
      eng_pass_done = (i == SAMPS - 1);
      #1;
      chk("run_mem_addr", 32'(mem_addr), i);
      @(negedge clk);
      if (i != SAMPS - 1 && eng_start === 1'b1) extra++;
    end
    eng_label_valid = 1'b0;
    eng_pass_done = 1'b0;
    for (int i = 0; i < SAMPS; i++) store[i] = cur[i];
    chk("eng_start_once", extra, 0);
  endtask

  task automatic run_job(input int mode, output int passes, output bit conv);
    int ch;
    bit seen = 0;
    passes = 0;
    conv = 0;
    for (int p = 1; p <= MAX_ITERS; p++) begin
      gen(mode, p);
      run_pass(p == 1, ch);
      passes = p;
      if (ch == 0) begin
        conv = 1;
        break;
      end
    end
    for (int w = 0; w < 6 && !seen; w++) begin
      if (class_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    chk("out_entered", seen, 1);
    chk("converged", converged, conv);
    chk("iters", 32'(iters), passes);
  endtask

  task automatic stream(input bit stall7, input int abort_at, output bit aborted);
    int idx = 0;
    int guard = 0;
    bit stalled = 0;
    bit r;
    aborted = 0;
    while (idx < SAMPS && guard < SAMPS * 6 && !aborted) begin
      guard++;
      chk("out_valid", class_valid, 1);
      chk("out_addr", 32'(class_addr), idx);
      chk("out_class", 32'(cls), store[idx]);
      if (idx == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
        class_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_valid", class_valid, 0);
        for (int w = 0; w < 4; w++) begin
          chk("abort_no_done", done, 0);
          @(negedge clk);
        end
        chk("abort_stay_idle", busy, 0);
        aborted = 1;
      end else begin
        r = ($urandom_range(0, 3) != 0);
        if (stall7 && idx == 7 && !stalled) begin
          stalled = 1;
          class_ready = 1'b0;
          // Engine activity outside RUN must not disturb the stored label.
          eng_addr = addr_t'(7);
          eng_class = label_t'((store[7] + 1) % K);
          eng_label_valid = 1'b1;
          repeat (5) begin
            @(negedge clk);
            chk("stall_addr", 32'(class_addr), 7);
            chk("stall_class", 32'(cls), store[7]);
          end
          eng_label_valid = 1'b0;
          r = 1'b1;
        end
        class_ready = r;
        if (r) idx++;
        @(negedge clk);
      end
    end
    class_ready = 1'b0;
    if (!aborted) begin
      chk("stream_count", idx, SAMPS);
      chk("done_pulse", done, 1);
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
        chk("done_once", done, 0);
        @(negedge clk);
      end
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    int passes;
    bit conv;
    bit ab;

    // Power-on reset
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", busy, 0);

    // Job A: identical labels on passes 1 and 2, stall at out_ptr 7
    load(1'b1);
    run_job(0, passes, conv);
    chk("jobA_iters_const", 32'(iters), 2);
    stream(1'b1, -1, ab);
    chk("jobA_hold_iters", 32'(iters), passes);
    chk("jobA_hold_conv", converged, 1);

    // Job B: one label flips every pass, so the limit is reached
    load(1'b0);
    run_job(1, passes, conv);
    chk("jobB_conv_const", converged, 0);
    chk("jobB_iters_const", 32'(iters), MAX_ITERS);
    stream(1'b0, -1, ab);

    // Reset in the middle of a pass
    load(1'b0);
    wait_eng_start();
    for (int i = 0; i < 20; i++) begin
      cur[i] = $urandom_range(0, K - 1);
      eng_addr = addr_t'(i);
      eng_class = label_t'(cur[i]);
      eng_label_valid = 1'b1;
      @(negedge clk);
      store[i] = cur[i];
    end
    eng_label_valid = 1'b0;
    eng_addr = addr_t'(85);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("rst_midrun");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", busy, 0);

    // Job C: first pass replays the stored labels and must still count all changes; abort in OUT
    load(1'b0);
    run_job(2, passes, conv);
    chk("jobC_iters_const", 32'(iters), 2);
    stream(1'b0, 10, ab);
    chk("jobC_aborted", ab, 1);

    // Job D: fresh job after abort, three passes to converge
    load(1'b0);
    run_job(3, passes, conv);
    chk("jobD_iters_const", 32'(iters), 3);
    stream(1'b0, -1, ab);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kmeans_iter_ctrl.md
KMEANS_ITER_CTRL -- requirements
Module: kmeans_iter_ctrl

Interface
REQ-001 SHALL have parameter SAMPS, default 128, meaning samples per data set (power of two).
REQ-002 SHALL have parameter K, default 3, meaning cluster count; labels are $clog2(K) bits wide.
REQ-003 SHALL have parameter MAX_ITERS, default 16, meaning the iteration limit (passes).
REQ-004 SHALL use one clock and an asynchronous active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, asynchronous reset, active-high.
REQ-005 SHALL have port start_i, input, 1 bit: begin load+cluster job; honoured only in IDLE.
REQ-006 SHALL have port abort_i, input, 1 bit: return to IDLE from any state.
REQ-007 SHALL have ports host_wr_valid_i (input, 1) and host_wr_ready_o (output, 1): sample-write handshake.
REQ-008 SHALL have ports mem_addr_o (output, $clog2(SAMPS)) and mem_we_o (output, 1): shared sample-memory port.
REQ-009 SHALL have port eng_start_o, output, 1 bit: one-cycle engine start pulse per pass.
REQ-010 SHALL have port eng_addr_i, input, $clog2(SAMPS): engine sample address.
REQ-011 SHALL have ports eng_class_i (input, label width) and eng_label_valid_i (input, 1): engine label for eng_addr_i.
REQ-012 SHALL have port eng_pass_done_i, input, 1 bit: engine finished one pass.
REQ-013 SHALL have ports class_valid_o (output, 1), class_ready_i (input, 1), class_o (output, label width) and class_addr_o (output, $clog2(SAMPS)): result stream.
REQ-014 SHALL have ports busy_o (output, 1), done_o (output, 1), converged_o (output, 1) and iters_o (output, $clog2(MAX_ITERS)+1): status.

Function
REQ-015 SHALL implement the states IDLE, LOAD, RUN, CHECK, OUT and DONE; busy_o=1 in every state except IDLE.
REQ-016 IDLE + start_i SHALL transition to LOAD next cycle, with wr_ptr=0, iter=0, and converged_o/iters_o cleared.
REQ-017 LOAD SHALL drive host_wr_ready_o=1, mem_addr_o=wr_ptr and mem_we_o=host_wr_valid_i, and SHALL increment wr_ptr on each accept; the accept at wr_ptr=SAMPS-1 SHALL transition to RUN.
REQ-018 In every state other than LOAD, host_wr_ready_o and mem_we_o SHALL be 0; host writes SHALL be ignored.
REQ-019 eng_start_o SHALL be 1 for exactly the first cycle of each RUN entry, and change_cnt SHALL clear on RUN entry.
REQ-020 RUN SHALL drive mem_addr_o=eng_addr_i combinationally (zero latency).
REQ-021 In RUN, on eng_label_valid_i, SHALL write eng_class_i into the label store at eng_addr_i and increment change_cnt (saturating at SAMPS) if iter==0 or the stored label differs.
REQ-022 In RUN, eng_pass_done_i SHALL transition to CHECK; a label arriving in the same cycle SHALL be counted first.
REQ-023 CHECK SHALL last 1 cycle and increment iter; if change_cnt==0, SHALL go to OUT with converged_o=1; else if iter+1==MAX_ITERS, SHALL go to OUT with converged_o=0; else SHALL go to RUN.
REQ-024 The first pass SHALL never converge: every label counts as a change.
REQ-025 OUT SHALL drive class_valid_o=1, class_addr_o=out_ptr and class_o=label[out_ptr], and SHALL advance out_ptr on class_ready_i; outputs SHALL hold stable while stalled; the last accept SHALL transition to DONE.
REQ-026 DONE SHALL assert done_o=1 for one cycle and then transition to IDLE; iters_o and converged_o SHALL hold until the next start_i.
REQ-027 abort_i SHALL have priority over all transitions: next state IDLE, eng_start_o=0, class_valid_o=0, done_o=0; labels SHALL be retained but are invalid.
REQ-028 start_i outside IDLE SHALL be ignored; a start_i asserted in the same cycle as abort_i SHALL be ignored.
REQ-029 eng_label_valid_i and eng_pass_done_i outside RUN SHALL be ignored.

Reset
REQ-030 rst_i SHALL asynchronously force state IDLE and zero all counters and pointers (wr_ptr, out_ptr, iter, change_cnt).
REQ-031 Under rst_i, every output SHALL be 0; the label store SHALL NOT be reset.
REQ-032 Deassertion of rst_i SHALL be synchronous to clk_i externally; the block SHALL NOT act on the first edge unless start_i is high.

Structure
REQ-033 kmeans_pkg SHALL hold SAMPS, K, the label and address typedefs, and the state enum.
REQ-034 The label store (SAMPS x label width; one write port, two asynchronous read ports for compare and OUT) SHALL be the sub-module kmeans_label_mem.

Verification
REQ-035 Reset mid-RUN -> all outputs 0 immediately and state IDLE; a following start_i -> LOAD.
REQ-036 Load 128 samples with host_wr_valid_i toggling every other cycle -> 128 writes at addresses 0..127, then eng_start_o pulses once.
REQ-037 Engine model returns identical labels on passes 1 and 2 -> CHECK exits after pass 2, converged_o=1, iters_o=2, 128 results streamed.
REQ-038 Engine model flips one label every pass -> 16 passes run, converged_o=0, iters_o=16.
REQ-039 OUT with class_ready_i held low for 5 cycles at out_ptr=7 -> class_o and class_addr_o stable at 7 throughout; done_o fires once after the 128th accept.
REQ-040 abort_i during OUT, then start_i -> no done_o, a fresh LOAD, and a first pass counting all 128 labels as changes.
